kf_spike_fanout: RTL and testbench

Tile-side receiver for spike flits leaving the router's local port: accepts one 32-bit AER flit at a time, looks up the presynaptic neuron's synapse range in the index RAM, and walks the synapse RAM. For every matching synapse it emits a postsynaptic update (post_id, Q8.8 weight, flags) to the neuron accumulator. It is the consumer end of the spike flit protocol whose producer is the tile's spike packetizer.

---
 rtl/kf_spike_fanout.sv | 163 ++++++++++++++++
 tb/tb_kf_spike_fanout.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_spike_fanout.sv
// Spike flit receiver: resolves a presynaptic neuron's synapse range and
// streams one postsynaptic update per matching synapse to the accumulator.
module kf_spike_fanout #(
  parameter int         NEURON_ID_BITS = 8,
  parameter int         SYN_ID_BITS    = 12,
  parameter logic [7:0] TILE_X         = 8'd0,
  parameter logic [7:0] TILE_Y         = 8'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flit_in_valid,
  input  logic [31:0]               flit_in_data,
  output logic                      flit_in_ready,
  output logic                      idx_rd_en,
  output logic [NEURON_ID_BITS-1:0] idx_rd_addr,
  input  logic [2*SYN_ID_BITS-1:0]  idx_rd_data,
  output logic                      syn_rd_en,
  output logic [SYN_ID_BITS-1:0]    syn_rd_addr,
  input  logic [31:0]               syn_rd_data,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [7:0]                upd_post_id,
  output logic signed [15:0]        upd_weight,
  output logic [7:0]                upd_flags,
  output logic [7:0]                upd_payload,
  output logic                      busy,
  output logic                      flit_done,
  output logic [15:0]               misroute_cnt,
  output logic [15:0]               mismatch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_IDX_RD, S_IDX_WAIT, S_SYN_RD, S_SYN_CHK, S_EMIT
  } state_t;

  state_t                    state_q;
  logic [NEURON_ID_BITS-1:0] neuron_q;
  logic [7:0]                payload_q;
  logic [SYN_ID_BITS-1:0]    cur_q;
  logic [SYN_ID_BITS-1:0]    cur_d;
  logic [SYN_ID_BITS-1:0]    end_q;
  logic                      upd_valid_q;
  logic [7:0]                post_q;
  logic signed [15:0]        weight_q;
  logic [7:0]                flags_q;
  logic [7:0]                upd_payload_q;
  logic                      done_q;
  logic [15:0]               misroute_q;
  logic [15:0]               mismatch_q;

  logic                      local_w;
  logic                      pre_match_w;
  logic                      last_w;
  logic [SYN_ID_BITS-1:0]    idx_start_w;
  logic [SYN_ID_BITS-1:0]    idx_end_w;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Q1.7 synapse weight to Q8.8 accumulator format
  function automatic logic signed [15:0] q17_to_q88(input logic [7:0] w);
    return $signed({{7{w[7]}}, w, 1'b0});
  endfunction

  assign local_w     = (flit_in_data[31:24] == TILE_X) && (flit_in_data[23:16] == TILE_Y);
  assign idx_start_w = idx_rd_data[2*SYN_ID_BITS-1:SYN_ID_BITS];
  assign idx_end_w   = idx_rd_data[SYN_ID_BITS-1:0];
  assign pre_match_w = (syn_rd_data[24 +: NEURON_ID_BITS] == neuron_q);
  // End test uses the pre-increment index so a range ending at the top never wraps
  assign last_w      = (cur_q == end_q);
  assign cur_d       = cur_q + {{(SYN_ID_BITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      neuron_q      <= '0;
      payload_q     <= '0;
      cur_q         <= '0;
      end_q         <= '0;
      upd_valid_q   <= 1'b0;
      post_q        <= '0;
      weight_q      <= '0;
      flags_q       <= '0;
      upd_payload_q <= '0;
      done_q        <= 1'b0;
      misroute_q    <= '0;
      mismatch_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (flit_in_valid) begin
            neuron_q  <= flit_in_data[8 +: NEURON_ID_BITS];
            payload_q <= flit_in_data[7:0];
            if (local_w) state_q <= S_IDX_RD;
            else         misroute_q <= sat_inc(misroute_q);
          end
        end
        S_IDX_RD: state_q <= S_IDX_WAIT;
        S_IDX_WAIT: begin
          if (idx_start_w > idx_end_w) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cur_q   <= idx_start_w;
            end_q   <= idx_end_w;
            state_q <= S_SYN_RD;
          end
        end
        S_SYN_RD: state_q <= S_SYN_CHK;
        S_SYN_CHK: begin
          if (pre_match_w) begin
            post_q        <= syn_rd_data[23:16];
            weight_q      <= q17_to_q88(syn_rd_data[15:8]);
            flags_q       <= syn_rd_data[7:0];
            upd_payload_q <= payload_q;
            upd_valid_q   <= 1'b1;
            state_q       <= S_EMIT;
          end else begin
            mismatch_q <= sat_inc(mismatch_q);
            if (last_w) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cur_q   <= cur_d;
              state_q <= S_SYN_RD;
            end
          end
        end
        S_EMIT: begin
          if (upd_ready) begin
            upd_valid_q <= 1'b0;
            if (last_w) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              cur_q   <= cur_d;
              state_q <= S_SYN_RD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign flit_in_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign idx_rd_en     = (state_q == S_IDX_RD);
  assign idx_rd_addr   = idx_rd_en ? neuron_q : '0;
  assign syn_rd_en     = (state_q == S_SYN_RD);
  assign syn_rd_addr   = syn_rd_en ? cur_q : '0;
  assign upd_valid     = upd_valid_q;
  assign upd_post_id   = post_q;
  assign upd_weight    = weight_q;
  assign upd_flags     = flags_q;
  assign upd_payload   = upd_payload_q;
  assign flit_done     = done_q;
  assign misroute_cnt  = misroute_q;
  assign mismatch_cnt  = mismatch_q;

endmodule

// File: tb/tb_kf_spike_fanout.sv
// Bench for kf_spike_fanout: RAM responders, a scoreboard fed by a range-walk
// model, a directed vector table, hand sequences and randomized flits.
module tb_kf_spike_fanout;
  logic        clk = 1'b0;
  logic        rst;
  logic        flit_in_valid;
  logic [31:0] flit_in_data;
  logic        flit_in_ready;
  logic        idx_rd_en;
  logic [7:0]  idx_rd_addr;
  logic [23:0] idx_rd_data;
  logic        syn_rd_en;
  logic [11:0] syn_rd_addr;
  logic [31:0] syn_rd_data;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_post_id;
  logic [15:0] upd_weight;
  logic [7:0]  upd_flags;
  logic [7:0]  upd_payload;
  logic        busy;
  logic        flit_done;
  logic [15:0] misroute_cnt;
  logic [15:0] mismatch_cnt;

  kf_spike_fanout #(.NEURON_ID_BITS(8), .SYN_ID_BITS(12), .TILE_X(8'd0), .TILE_Y(8'd0)) dut (
    .clk(clk), .rst(rst), .flit_in_valid(flit_in_valid), .flit_in_data(flit_in_data),
    .flit_in_ready(flit_in_ready), .idx_rd_en(idx_rd_en), .idx_rd_addr(idx_rd_addr),
    .idx_rd_data(idx_rd_data), .syn_rd_en(syn_rd_en), .syn_rd_addr(syn_rd_addr),
    .syn_rd_data(syn_rd_data), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_post_id(upd_post_id), .upd_weight(upd_weight), .upd_flags(upd_flags),
    .upd_payload(upd_payload), .busy(busy), .flit_done(flit_done),
    .misroute_cnt(misroute_cnt), .mismatch_cnt(mismatch_cnt));

  always #5 clk = ~clk;

  logic [23:0] idx_mem [256];
  logic [31:0] syn_mem [4096];

  always @(posedge clk) begin
    if (idx_rd_en) idx_rd_data <= idx_mem[idx_rd_addr];
    if (syn_rd_en) syn_rd_data <= syn_mem[syn_rd_addr];
  end

  typedef struct {
    logic [7:0]  post;
    logic [15:0] w;
    logic [7:0]  flags;
    logic [7:0]  pay;
  } upd_t;

  typedef struct {
    logic [31:0] flit;
    int          exp_upd;
    int          exp_mis;
    int          exp_misroute;
    int          exp_done;
    int          exp_idx;
  } vec_t;

  upd_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  int tot_idx = 0, tot_syn = 0, tot_upd = 0, tot_done = 0, syn_zero = 0, stall_chk = 0;
  int acc_cyc = 0, first_idx = -1, first_syn = -1, first_upd = -1, done_cyc = 0;
  int hs_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_w(input logic [7:0] w);
    int v;
    v = int'(w);
    if (v > 127) v = v - 256;
    v = v * 2;
    return 16'(v);
  endfunction

  // Reference: walk the index range with plain arithmetic, queue every match
  task automatic model_push(input logic [31:0] f, output int n_upd, output int n_mis);
    logic [7:0]  nid;
    logic [23:0] ix;
    logic [31:0] s;
    int          lo, hi;
    upd_t        u;
    n_upd = 0;
    n_mis = 0;
    nid = f[15:8];
    ix  = idx_mem[nid];
    lo  = int'(ix[23:12]);
    hi  = int'(ix[11:0]);
    if (f[31:24] == 8'd0 && f[23:16] == 8'd0) begin
      for (int a = lo; a <= hi; a++) begin
        s = syn_mem[a];
        if (s[31:24] == nid) begin
          u.post = s[23:16]; u.w = model_w(s[15:8]); u.flags = s[7:0]; u.pay = f[7:0];
          exp_q.push_back(u);
          n_upd++;
        end else n_mis++;
      end
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: latencies, handshakes, hold-while-stalled and scoreboard
  initial begin
    logic        prev_stall;
    logic [7:0]  pv_post, pv_flags, pv_pay;
    logic [15:0] pv_w;
    upd_t        e;
    prev_stall = 1'b0;
    pv_post = '0; pv_flags = '0; pv_pay = '0; pv_w = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (flit_in_valid && flit_in_ready) begin
          acc_cyc = cyc; first_idx = -1; first_syn = -1; first_upd = -1;
          hs_q.delete();
        end
        if (idx_rd_en) begin tot_idx++; if (first_idx < 0) first_idx = cyc; end
        if (syn_rd_en) begin
          tot_syn++;
          if (first_syn < 0) first_syn = cyc;
          if (syn_rd_addr == 12'd0) syn_zero++;
        end
        if (upd_valid && first_upd < 0) first_upd = cyc;
        if (prev_stall) begin
          stall_chk++;
          chk("hold_valid", upd_valid, 1);
          chk("hold_post", upd_post_id, pv_post);
          chk("hold_weight", upd_weight, pv_w);
          chk("hold_flags", upd_flags, pv_flags);
          chk("hold_payload", upd_payload, pv_pay);
        end
        if (upd_valid && upd_ready) begin
          hs_q.push_back(cyc);
          tot_upd++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL upd_unexpected: got update post=0x%0h, required none", upd_post_id);
          end else begin
            e = exp_q.pop_front();
            chk("upd_post_id", upd_post_id, e.post);
            chk("upd_weight", upd_weight, e.w);
            chk("upd_flags", upd_flags, e.flags);
            chk("upd_payload", upd_payload, e.pay);
          end
        end
        if (flit_done) begin tot_done++; done_cyc = cyc; end
        prev_stall = upd_valid && !upd_ready;
        pv_post = upd_post_id; pv_w = upd_weight; pv_flags = upd_flags; pv_pay = upd_payload;
      end
    end
  end

  task automatic send_flit(input logic [31:0] f);
    int n;
    n = 0;
    flit_in_valid = 1'b1;
    flit_in_data  = f;
    while (!flit_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    flit_in_valid = 1'b0;
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL flit_accept_timeout: got ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_done(input int snap, input bit rnd, input int lim);
    int n;
    n = 0;
    while (tot_done == snap && n < lim) begin
      @(posedge clk); #1;
      if (rnd) upd_ready = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (tot_done == snap) begin
      failures++;
      $display("FAIL flit_done_timeout: got no pulse in %0d cycles, required 1", lim);
    end
  endtask

  task automatic wait_valid(input string name, input int lim);
    int n;
    n = 0;
    while (!upd_valid && n < lim) begin @(posedge clk); #1; n++; end
    chk(name, upd_valid, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, flit_in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx_en"}, idx_rd_en, 0);
    chk({tag, "_syn_en"}, syn_rd_en, 0);
    chk({tag, "_upd_valid"}, upd_valid, 0);
    chk({tag, "_done"}, flit_done, 0);
    chk({tag, "_misroute"}, misroute_cnt, 0);
    chk({tag, "_mismatch"}, mismatch_cnt, 0);
    chk({tag, "_upd_data"}, {upd_post_id, upd_weight, upd_flags, upd_payload}, 0);
    chk({tag, "_addrs"}, {idx_rd_addr, syn_rd_addr}, 0);
  endtask

  initial begin
    vec_t        tbl[6];
    upd_t        u;
    int          s_upd, s_done, s_idx, s_syn, s_zero, s_stall, nu, nm;
    logic [15:0] s_mr, s_mm;
    logic [7:0]  nid;
    int          lo, len, hi;
    bit          is_local;
    logic [31:0] f;

    rst = 1'b1; flit_in_valid = 1'b0; flit_in_data = '0; upd_ready = 1'b0;
    for (int i = 0; i < 256; i++)  idx_mem[i] = {12'd1, 12'd0};
    for (int i = 0; i < 4096; i++) syn_mem[i] = 32'hFF00_0000;
    idx_mem[5]  = {12'd10, 12'd12};
    syn_mem[10] = {8'd5, 8'd1, 8'h40, 8'h01};
    syn_mem[11] = {8'd5, 8'd2, 8'hC0, 8'h82};
    syn_mem[12] = {8'd5, 8'd3, 8'h7F, 8'h03};
    idx_mem[7]  = {12'd20, 12'd19};
    idx_mem[9]  = {12'd4094, 12'd4095};
    syn_mem[4094] = {8'd9, 8'h11, 8'h80, 8'hA5};
    syn_mem[4095] = {8'd9, 8'h12, 8'h01, 8'h5A};
    idx_mem[11] = {12'd30, 12'd32};
    syn_mem[30] = {8'd11, 8'h21, 8'h10, 8'h00};
    syn_mem[31] = {8'd99, 8'h22, 8'h20, 8'h00};
    syn_mem[32] = {8'd11, 8'h23, 8'hF0, 8'h04};

    tbl[0] = '{{8'd0, 8'd0, 8'd5,  8'hA1}, 3, 0, 0, 1, 1};
    tbl[1] = '{{8'd1, 8'd0, 8'd5,  8'h00}, 0, 0, 1, 0, 0};
    tbl[2] = '{{8'd0, 8'd3, 8'd5,  8'h00}, 0, 0, 1, 0, 0};
    tbl[3] = '{{8'd0, 8'd0, 8'd7,  8'h33}, 0, 0, 0, 1, 1};
    tbl[4] = '{{8'd0, 8'd0, 8'd11, 8'h44}, 2, 1, 0, 1, 1};
    tbl[5] = '{{8'd0, 8'd0, 8'd9,  8'h55}, 2, 0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Neuron 5: three updates, latency and back-to-back handshake spacing
    upd_ready = 1'b1;
    s_done = tot_done; s_upd = tot_upd;
    u.post = 8'd1; u.w = 16'h0080; u.flags = 8'h01; u.pay = 8'h77; exp_q.push_back(u);
    u.post = 8'd2; u.w = 16'hFF80; u.flags = 8'h82; exp_q.push_back(u);
    u.post = 8'd3; u.w = 16'h00FE; u.flags = 8'h03; exp_q.push_back(u);
    send_flit({8'd0, 8'd0, 8'd5, 8'h77});
    wait_done(s_done, 1'b0, 100);
    chk("lat_idx_rd", first_idx - acc_cyc, 1);
    chk("lat_syn_rd", first_syn - acc_cyc, 3);
    chk("lat_upd_valid", first_upd - acc_cyc, 5);
    chk("n5_updates", tot_upd - s_upd, 3);
    chk("n5_done", tot_done - s_done, 1);
    chk("n5_hs_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("hs_spacing", hs_q[1] - hs_q[0], 3);
      chk("done_after_hs", done_cyc - hs_q[2], 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("n5_done_single", tot_done - s_done, 1);

    // Empty range
    s_done = tot_done; s_syn = tot_syn;
    send_flit({8'd0, 8'd0, 8'd7, 8'h00});
    wait_done(s_done, 1'b0, 50);
    chk("empty_done_lat", done_cyc - acc_cyc, 3);
    chk("empty_no_syn", tot_syn - s_syn, 0);

    // Misroute: ready stays high, counter visible the next cycle
    s_idx = tot_idx; s_mr = misroute_cnt;
    send_flit({8'd1, 8'd0, 8'd5, 8'h00});
    chk("misroute_inc", misroute_cnt - s_mr, 1);
    chk("misroute_ready", flit_in_ready, 1);
    chk("misroute_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("misroute_no_idx", tot_idx - s_idx, 0);

    // Top-of-memory range with a stalled first update
    upd_ready = 1'b0;
    s_done = tot_done; s_upd = tot_upd; s_zero = syn_zero; s_syn = tot_syn; s_stall = stall_chk;
    model_push({8'd0, 8'd0, 8'd9, 8'hC3}, nu, nm);
    send_flit({8'd0, 8'd0, 8'd9, 8'hC3});
    wait_valid("top_first_valid", 20);
    repeat (4) @(posedge clk);
    #1;
    chk("top_still_valid", upd_valid, 1);
    upd_ready = 1'b1;
    wait_done(s_done, 1'b0, 100);
    chk("top_updates", tot_upd - s_upd, 2);
    chk("top_syn_reads", tot_syn - s_syn, 2);
    chk("top_no_addr0", syn_zero - s_zero, 0);
    chk("top_stall_seen", (stall_chk - s_stall) >= 4, 1);
    chk("top_queue_empty", exp_q.size(), 0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      s_upd = tot_upd; s_done = tot_done; s_idx = tot_idx;
      s_mr = misroute_cnt; s_mm = mismatch_cnt;
      model_push(tbl[i].flit, nu, nm);
      send_flit(tbl[i].flit);
      if (tbl[i].exp_done != 0) wait_done(s_done, 1'b1, 300);
      else begin repeat (4) @(posedge clk); #1; end
      chk($sformatf("tbl%0d_upd", i), tot_upd - s_upd, tbl[i].exp_upd);
      chk($sformatf("tbl%0d_mismatch", i), mismatch_cnt - s_mm, tbl[i].exp_mis);
      chk($sformatf("tbl%0d_misroute", i), misroute_cnt - s_mr, tbl[i].exp_misroute);
      chk($sformatf("tbl%0d_done", i), tot_done - s_done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_idx", i), tot_idx - s_idx, tbl[i].exp_idx);
      chk($sformatf("tbl%0d_queue", i), exp_q.size(), 0);
      upd_ready = 1'b1;
    end

    // Mismatch in the middle, then reset during the second EMIT
    upd_ready = 1'b0;
    s_done = tot_done; s_upd = tot_upd; s_mm = mismatch_cnt;
    model_push({8'd0, 8'd0, 8'd11, 8'h66}, nu, nm);
    send_flit({8'd0, 8'd0, 8'd11, 8'h66});
    wait_valid("rst_first_valid", 20);
    upd_ready = 1'b1;
    @(posedge clk); #1;
    upd_ready = 1'b0;
    wait_valid("rst_second_valid", 20);
    chk("rst_first_upd", tot_upd - s_upd, 1);
    chk("rst_mismatch", mismatch_cnt - s_mm, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("abort");
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", tot_done - s_done, 0);
    chk("abort_no_upd", tot_upd - s_upd, 1);

    // Randomized flits against the range-walk model
    for (int k = 0; k < 40; k++) begin
      nid = 8'($urandom_range(16, 31));
      lo  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4090, 4095)) : int'($urandom_range(100, 4000));
      len = int'($urandom_range(0, 6)) - 1;
      hi  = lo + len;
      if (hi > 4095) hi = 4095;
      idx_mem[nid] = {12'(lo), 12'(hi)};
      for (int a = lo; a <= hi; a++)
        syn_mem[a] = {($urandom_range(0, 3) == 0) ? 8'($urandom) : nid,
                      8'($urandom), 8'($urandom), 8'($urandom)};
      is_local = ($urandom_range(0, 6) != 0);
      f = {is_local ? 8'd0 : 8'($urandom_range(1, 255)), 8'd0, nid, 8'($urandom)};
      s_upd = tot_upd; s_done = tot_done; s_mr = misroute_cnt; s_mm = mismatch_cnt;
      model_push(f, nu, nm);
      send_flit(f);
      if (is_local) wait_done(s_done, 1'b1, 400);
      else begin repeat (3) @(posedge clk); #1; end
      chk("rnd_upd", tot_upd - s_upd, nu);
      chk("rnd_mismatch", mismatch_cnt - s_mm, nm);
      chk("rnd_misroute", misroute_cnt - s_mr, is_local ? 0 : 1);
      chk("rnd_done", tot_done - s_done, is_local ? 1 : 0);
      chk("rnd_queue", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1);
  end

endmodule
